// File: rtl/cmd_arbiter_if.sv
// Bundle of the arbiter's request, command and response signals.
// slave is the arbiter's view; master is the requester/cmd_proc view.
interface cmd_arbiter_if;
  logic [15:0] uart_cmd;
  logic        uart_vld;
  logic        uart_ovf;
  logic [15:0] tour_cmd;
  logic        tour_last;
  logic        tour_vld;
  logic        tour_rdy;
  logic        tour_ack;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  logic        resp_vld;
  logic        owner;

  modport slave (
    input  uart_cmd, uart_vld, tour_cmd, tour_last, tour_vld, clr_cmd_rdy, send_resp,
    output uart_ovf, tour_rdy, tour_ack, cmd, cmd_rdy, resp, resp_vld, owner
  );

  modport master (
    output uart_cmd, uart_vld, tour_cmd, tour_last, tour_vld, clr_cmd_rdy, send_resp,
    input  uart_ovf, tour_rdy, tour_ack, cmd, cmd_rdy, resp, resp_vld, owner
  );
endinterface

// File: rtl/cmd_arbiter.sv
// cmd_arbiter: shares the cmd_proc command port between the UART command
// path (src 0, FIFO buffered) and the tour sequencer (src 1, single holding
// register). Round-robin, one command in flight, watchdog abort in EXEC.
module cmd_arbiter #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 150000000,
  parameter int TO_W    = 28
) (
  input  logic           clk,
  input  logic           rst,
  cmd_arbiter_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam bit WD_EN = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = WD_EN ? TO_W'(TIMEOUT - 1) : '0;

  localparam logic [7:0] RESP_OK_A = 8'hA5;
  localparam logic [7:0] RESP_OK_B = 8'h5A;
  localparam logic [7:0] RESP_ERR  = 8'hEE;

  typedef enum logic [1:0] {IDLE, ISSUE, EXEC, RESP} state_t;

  state_t state_q, state_d;

  // UART FIFO: pointers carry one extra wrap bit to tell full from empty
  logic [DEPTH-1:0][15:0] fifo_q, fifo_d;
  logic [AW:0]            wr_ptr_q, wr_ptr_d;
  logic [AW:0]            rd_ptr_q, rd_ptr_d;
  logic                   ovf_q, ovf_d;

  // tour holding register
  logic                   tvld_q, tvld_d;
  logic [15:0]            tcmd_q, tcmd_d;
  logic                   tlast_q, tlast_d;

  // command in flight
  logic [15:0]            cmd_q, cmd_d;
  logic                   cmd_rdy_q, cmd_rdy_d;
  logic                   owner_q, owner_d;
  logic                   last_q, last_d;
  logic                   last_grant_q, last_grant_d;
  logic [TO_W-1:0]        wd_q, wd_d;
  logic [7:0]             resp_q, resp_d;
  logic                   resp_vld_q, resp_vld_d;
  logic                   tour_ack_q, tour_ack_d;

  logic fifo_empty, fifo_full;
  logic uart_pend, tour_pend;
  logic gnt_uart, gnt_tour;
  logic push_ok;
  logic [7:0] ok_code;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign uart_pend = ~fifo_empty;
  assign tour_pend = tvld_q;

  // On a tie the source that did not win last time goes next
  assign gnt_tour = (state_q == IDLE) && tour_pend && (~uart_pend || ~last_grant_q);
  assign gnt_uart = (state_q == IDLE) && uart_pend && ~gnt_tour;

  // A pop in the same cycle frees a slot, so a full FIFO can still take a push
  assign push_ok = bus.uart_vld && (~fifo_full || gnt_uart);

  // Tour moves that are not the final move get the alternate ack code
  assign ok_code = (~owner_q || last_q) ? RESP_OK_A : RESP_OK_B;

  // FIFO storage and pointer next-state
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (push_ok) begin
      fifo_d[wr_ptr_q[AW-1:0]] = bus.uart_cmd;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (bus.uart_vld && ~push_ok) ovf_d = 1'b1;
    if (gnt_uart) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Tour holding register next-state; pushes while occupied are ignored
  always_comb begin
    tvld_d  = tvld_q;
    tcmd_d  = tcmd_q;
    tlast_d = tlast_q;
    if (gnt_tour) begin
      tvld_d = 1'b0;
    end else if (bus.tour_vld && ~tvld_q) begin
      tvld_d  = 1'b1;
      tcmd_d  = bus.tour_cmd;
      tlast_d = bus.tour_last;
    end
  end

  // Arbitration / handshake FSM next-state and registered outputs
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    cmd_rdy_d    = cmd_rdy_q;
    owner_d      = owner_q;
    last_d       = last_q;
    last_grant_d = last_grant_q;
    wd_d         = wd_q;
    resp_d       = resp_q;
    resp_vld_d   = 1'b0;
    tour_ack_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_tour) begin
          cmd_d        = tcmd_q;
          owner_d      = 1'b1;
          last_d       = tlast_q;
          last_grant_d = 1'b1;
          cmd_rdy_d    = 1'b1;
          state_d      = ISSUE;
        end else if (gnt_uart) begin
          cmd_d        = fifo_q[rd_ptr_q[AW-1:0]];
          owner_d      = 1'b0;
          last_d       = 1'b0;
          last_grant_d = 1'b0;
          cmd_rdy_d    = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.clr_cmd_rdy) begin
          cmd_rdy_d = 1'b0;
          wd_d      = '0;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        // send_resp outranks a watchdog expiry in the same cycle
        if (bus.send_resp) begin
          resp_d     = ok_code;
          resp_vld_d = 1'b1;
          tour_ack_d = owner_q;
          state_d    = RESP;
        end else if (WD_EN && (wd_q == TO_LAST)) begin
          resp_d     = RESP_ERR;
          resp_vld_d = 1'b1;
          tour_ack_d = owner_q;
          state_d    = RESP;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, pointers and outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ovf_q        <= 1'b0;
      tvld_q       <= 1'b0;
      tcmd_q       <= '0;
      tlast_q      <= 1'b0;
      cmd_q        <= '0;
      cmd_rdy_q    <= 1'b0;
      owner_q      <= 1'b0;
      last_q       <= 1'b0;
      last_grant_q <= 1'b1;
      wd_q         <= '0;
      resp_q       <= '0;
      resp_vld_q   <= 1'b0;
      tour_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ovf_q        <= ovf_d;
      tvld_q       <= tvld_d;
      tcmd_q       <= tcmd_d;
      tlast_q      <= tlast_d;
      cmd_q        <= cmd_d;
      cmd_rdy_q    <= cmd_rdy_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      last_grant_q <= last_grant_d;
      wd_q         <= wd_d;
      resp_q       <= resp_d;
      resp_vld_q   <= resp_vld_d;
      tour_ack_q   <= tour_ack_d;
    end
  end

  // FIFO data array; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign bus.uart_ovf = ovf_q;
  assign bus.tour_rdy = ~tvld_q;
  assign bus.tour_ack = tour_ack_q;
  assign bus.cmd      = cmd_q;
  assign bus.cmd_rdy  = cmd_rdy_q;
  assign bus.resp     = resp_q;
  assign bus.resp_vld = resp_vld_q;
  assign bus.owner    = owner_q;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Bench for cmd_arbiter: scenario tasks drive stimulus and push expected
// grants/responses to a scoreboard; negedge monitors pop and compare.
module tb_cmd_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cmd_arbiter_if bus();

  cmd_arbiter #(.DEPTH(4), .TIMEOUT(20), .TO_W(28)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] cmd;
    logic        owner;
    logic [7:0]  resp;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend_q[$];
  exp_t mon_e;
  logic rdy_prev = 1'b0;

  // Grant and response scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cmd_rdy && !rdy_prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL grant_unexpected: got cmd=%h owner=%0d, required no grant", bus.cmd, bus.owner);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus.cmd !== mon_e.cmd || bus.owner !== mon_e.owner) begin
            errors++;
            $display("FAIL grant: got cmd=%h owner=%0d, required cmd=%h owner=%0d",
                     bus.cmd, bus.owner, mon_e.cmd, mon_e.owner);
          end
          pend_q.push_back(mon_e);
        end
      end
      if (bus.resp_vld) begin
        checks++;
        if (pend_q.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: got resp=%h, required no resp_vld", bus.resp);
        end else begin
          mon_e = pend_q.pop_front();
          if (bus.resp !== mon_e.resp || bus.tour_ack !== mon_e.owner) begin
            errors++;
            $display("FAIL resp: got resp=%h tour_ack=%0d, required resp=%h tour_ack=%0d",
                     bus.resp, bus.tour_ack, mon_e.resp, mon_e.owner);
          end
        end
      end
    end
    rdy_prev = bus.cmd_rdy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] c, input logic o, input logic [7:0] r);
    exp_t e;
    e.cmd = c; e.owner = o; e.resp = r;
    exp_q.push_back(e);
  endtask

  task automatic push_uart(input logic [15:0] c);
    bus.uart_cmd = c;
    bus.uart_vld = 1'b1;
    tick();
    bus.uart_vld = 1'b0;
  endtask

  task automatic push_tour(input logic [15:0] c, input logic l);
    bus.tour_cmd  = c;
    bus.tour_last = l;
    bus.tour_vld  = 1'b1;
    tick();
    bus.tour_vld = 1'b0;
  endtask

  task automatic wait_rdy(input string name);
    int n = 0;
    while (!bus.cmd_rdy && n < 50) begin
      tick();
      n++;
    end
    if (!bus.cmd_rdy) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: cmd_rdy=0 after 50 cycles, required 1", name);
    end
  endtask

  task automatic serve(input string name);
    wait_rdy(name);
    bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;
    tick();
    bus.send_resp = 1'b1;
    tick();
    bus.send_resp = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    pend_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.cmd, bus.cmd_rdy, bus.resp, bus.resp_vld} !== {16'h0, 1'b0, 8'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_cmd_resp: got cmd=%h rdy=%0d resp=%h vld=%0d, required 0 0 0 0",
               bus.cmd, bus.cmd_rdy, bus.resp, bus.resp_vld);
    end
    checks++;
    if ({bus.tour_ack, bus.owner, bus.uart_ovf, bus.tour_rdy} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_flags: got ack=%0d owner=%0d ovf=%0d tour_rdy=%0d, required 0 0 0 1",
               bus.tour_ack, bus.owner, bus.uart_ovf, bus.tour_rdy);
    end
  endtask

  task automatic test_single_uart();
    push_exp(16'h4BF1, 1'b0, 8'hA5);
    push_uart(16'h4BF1);
    checks++;
    if (bus.cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL latency_1: got cmd_rdy=%0d, required 0", bus.cmd_rdy);
    end
    tick();
    checks++;
    if (bus.cmd_rdy !== 1'b1) begin
      errors++;
      $display("FAIL latency_2: got cmd_rdy=%0d, required 1", bus.cmd_rdy);
    end
    bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;
    checks++;
    if (bus.cmd_rdy !== 1'b0 || bus.cmd !== 16'h4BF1) begin
      errors++;
      $display("FAIL clr_drop: got cmd_rdy=%0d cmd=%h, required 0 4bf1", bus.cmd_rdy, bus.cmd);
    end
    bus.send_resp = 1'b1;
    tick();
    bus.send_resp = 1'b0;
    checks++;
    if (bus.resp_vld !== 1'b1 || bus.resp !== 8'hA5) begin
      errors++;
      $display("FAIL single_resp: got vld=%0d resp=%h, required 1 a5", bus.resp_vld, bus.resp);
    end
    tick();
    checks++;
    if (bus.resp_vld !== 1'b0) begin
      errors++;
      $display("FAIL resp_strobe: got resp_vld=%0d, required 0", bus.resp_vld);
    end
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    push_exp(16'h1111, 1'b0, 8'hA5);
    push_exp(16'h5002, 1'b1, 8'h5A);
    bus.uart_cmd  = 16'h1111;
    bus.uart_vld  = 1'b1;
    bus.tour_cmd  = 16'h5002;
    bus.tour_last = 1'b0;
    bus.tour_vld  = 1'b1;
    tick();
    bus.uart_vld = 1'b0;
    bus.tour_vld = 1'b0;
    checks++;
    if (bus.tour_rdy !== 1'b0) begin
      errors++;
      $display("FAIL tour_rdy_busy: got %0d, required 0", bus.tour_rdy);
    end
    serve("rr_uart");
    serve("rr_tour");
    checks++;
    if (bus.tour_rdy !== 1'b1) begin
      errors++;
      $display("FAIL tour_rdy_free: got %0d, required 1", bus.tour_rdy);
    end
    push_exp(16'h5003, 1'b1, 8'hA5);
    push_tour(16'h5003, 1'b1);
    serve("tour_last");
  endtask

  task automatic test_overflow();
    push_exp(16'h3000, 1'b0, 8'hA5);
    push_uart(16'h3000);
    wait_rdy("ovf_first");
    for (int i = 1; i <= 4; i++) begin
      push_exp(16'h3000 + 16'(i), 1'b0, 8'hA5);
      push_uart(16'h3000 + 16'(i));
    end
    checks++;
    if (bus.uart_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_early: got uart_ovf=%0d, required 0", bus.uart_ovf);
    end
    push_uart(16'h3005);
    checks++;
    if (bus.uart_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got uart_ovf=%0d, required 1", bus.uart_ovf);
    end
    for (int i = 0; i < 5; i++) serve("ovf_drain");
    tick();
    checks++;
    if (exp_q.size() != 0 || pend_q.size() != 0 || bus.uart_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drain: got pending=%0d/%0d ovf=%0d, required 0/0 1",
               exp_q.size(), pend_q.size(), bus.uart_ovf);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    push_exp(16'h0404, 1'b0, 8'hEE);
    push_uart(16'h0404);
    wait_rdy("timeout");
    bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;
    while (!bus.resp_vld && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != 20 || bus.resp !== 8'hEE) begin
      errors++;
      $display("FAIL timeout: got %0d exec cycles resp=%h, required 20 ee", n, bus.resp);
    end
    tick();
    checks++;
    if (bus.resp_vld !== 1'b0 || bus.cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: got vld=%0d rdy=%0d, required 0 0", bus.resp_vld, bus.cmd_rdy);
    end
    tick();
  endtask

  task automatic test_resp_vs_timeout();
    push_exp(16'h0505, 1'b0, 8'hA5);
    push_uart(16'h0505);
    wait_rdy("race");
    bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    bus.send_resp = 1'b1;
    tick();
    bus.send_resp = 1'b0;
    checks++;
    if (bus.resp_vld !== 1'b1 || bus.resp !== 8'hA5) begin
      errors++;
      $display("FAIL resp_wins: got vld=%0d resp=%h, required 1 a5", bus.resp_vld, bus.resp);
    end
    tick();
    tick();
  endtask

  task automatic test_reset_exec();
    int seen = 0;
    push_exp(16'h0606, 1'b0, 8'hA5);
    push_uart(16'h0606);
    wait_rdy("rst_exec");
    bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;
    push_uart(16'h0607);
    push_uart(16'h0608);
    rst = 1'b1;
    exp_q.delete();
    pend_q.delete();
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.cmd_rdy, bus.tour_rdy, bus.uart_ovf, bus.resp_vld} !== 4'b0100) begin
      errors++;
      $display("FAIL rst_exec: got rdy=%0d tour_rdy=%0d ovf=%0d vld=%0d, required 0 1 0 0",
               bus.cmd_rdy, bus.tour_rdy, bus.uart_ovf, bus.resp_vld);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.cmd_rdy || bus.resp_vld) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_flush: got %0d active cycles after reset, required 0", seen);
    end
  endtask

  initial begin
    bus.uart_cmd    = '0;
    bus.uart_vld    = 1'b0;
    bus.tour_cmd    = '0;
    bus.tour_last   = 1'b0;
    bus.tour_vld    = 1'b0;
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp   = 1'b0;
    test_reset();
    test_single_uart();
    test_round_robin();
    test_overflow();
    test_timeout();
    test_resp_vs_timeout();
    test_reset_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000, required finish");
    $fatal(1, "global timeout");
  end

endmodule
